// File: rtl/dwrr_deficit_table.sv
// Per-flow DWRR deficit counters with round-robin replenish, debit, saturation and registered readback.
// Optional runtime quantum programming is compiled in with `define DWRR_QUANTUM_WR_EN.
module dwrr_deficit_table #(
  parameter int NUM_FLOWS       = 8,
  parameter int FLOW_W          = $clog2(NUM_FLOWS),
  parameter int CREDIT_W        = 12,
  parameter int LEN_W           = 10,
  parameter int QUANTUM_W       = 10,
  parameter int DEFAULT_QUANTUM = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       init_done,
  input  logic                       replenish_valid,
  output logic [FLOW_W-1:0]          replenish_flow,
  input  logic                       consume_valid,
  input  logic [FLOW_W-1:0]          consume_flow,
  input  logic [LEN_W-1:0]           consume_len,
  input  logic [FLOW_W-1:0]          query_flow,
  output logic signed [CREDIT_W-1:0] query_credit,
  output logic [NUM_FLOWS-1:0]       eligible_mask,
  input  logic                       quantum_wr_en,
  input  logic [FLOW_W-1:0]          quantum_wr_flow,
  input  logic [QUANTUM_W-1:0]       quantum_wr_data,
  output logic                       sat_event
);

  // Two guard bits hold credit + quantum - len without wrapping before the clamp.
  localparam int SUM_W = CREDIT_W + 2;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (CREDIT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [FLOW_W-1:0] LAST_FLOW = FLOW_W'(NUM_FLOWS - 1);
  localparam logic signed [CREDIT_W-1:0] DEFAULT_CREDIT = CREDIT_W'(DEFAULT_QUANTUM);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                      state_reg, state_next;
  logic [FLOW_W-1:0]           idx_reg, idx_next;
  logic [FLOW_W-1:0]           ptr_reg;
  logic signed [CREDIT_W-1:0]  credit_reg [NUM_FLOWS];
  logic signed [CREDIT_W-1:0]  credit_next [NUM_FLOWS];
  logic [QUANTUM_W-1:0]        quantum_val [NUM_FLOWS];
  logic [NUM_FLOWS-1:0]        sat_flag;
  logic [NUM_FLOWS-1:0]        mask_reg;
  logic signed [CREDIT_W-1:0]  query_credit_reg;
  logic                        sat_reg;
  logic                        run;

  assign run            = (state_reg == S_RUN);
  assign init_done      = run;
  assign replenish_flow = ptr_reg;
  assign query_credit   = query_credit_reg;
  assign eligible_mask  = mask_reg;
  assign sat_event      = sat_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_INIT;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    if (state_reg == S_INIT) begin
      if (idx_reg == LAST_FLOW) begin
        state_next = S_RUN;
        idx_next   = '0;
      end else begin
        idx_next = idx_reg + 1'b1;
      end
    end
  end

`ifdef DWRR_QUANTUM_WR_EN
  logic [QUANTUM_W-1:0] quantum_reg [NUM_FLOWS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_reg == S_INIT)
        quantum_reg[idx_reg] <= QUANTUM_W'(DEFAULT_QUANTUM);
      else if (quantum_wr_en && (32'(quantum_wr_flow) < NUM_FLOWS))
        quantum_reg[quantum_wr_flow] <= quantum_wr_data;
    end
  end
`else
  logic unused_quantum_wr;
  assign unused_quantum_wr = &{1'b0, quantum_wr_en, quantum_wr_flow, quantum_wr_data};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLOWS; gi++) begin : g_flow
      logic                    rep_hit, con_hit, over, under;
      logic signed [SUM_W-1:0] q_ext, l_ext, sum;

`ifdef DWRR_QUANTUM_WR_EN
      assign quantum_val[gi] = quantum_reg[gi];
`else
      assign quantum_val[gi] = QUANTUM_W'(DEFAULT_QUANTUM);
`endif
      assign rep_hit = run && replenish_valid && (ptr_reg == FLOW_W'(gi));
      assign con_hit = run && consume_valid && (consume_flow == FLOW_W'(gi));
      assign q_ext   = rep_hit ? SUM_W'(quantum_val[gi]) : '0;
      assign l_ext   = con_hit ? SUM_W'(consume_len) : '0;
      // Same-flow replenish and debit collapse into one sum, so only one clamp applies.
      assign sum     = SUM_W'(credit_reg[gi]) + q_ext - l_ext;
      assign over    = (sum > SAT_MAX);
      assign under   = (sum < SAT_MIN);
      assign sat_flag[gi]    = over | under;
      assign credit_next[gi] = over  ? SAT_MAX[CREDIT_W-1:0] :
                               under ? SAT_MIN[CREDIT_W-1:0] : sum[CREDIT_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_FLOWS; i++) begin
        if (state_reg == S_INIT) begin
          if (idx_reg == FLOW_W'(i))
            credit_reg[i] <= DEFAULT_CREDIT;
        end else begin
          credit_reg[i] <= credit_next[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg          <= '0;
      query_credit_reg <= '0;
      mask_reg         <= '0;
      sat_reg          <= 1'b0;
    end else begin
      if (run && replenish_valid)
        ptr_reg <= (ptr_reg == LAST_FLOW) ? '0 : ptr_reg + 1'b1;
      // Readback sees the table as it stood before this cycle's updates.
      query_credit_reg <= (32'(query_flow) < NUM_FLOWS) ? credit_reg[query_flow] : '0;
      for (int i = 0; i < NUM_FLOWS; i++)
        mask_reg[i] <= !credit_reg[i][CREDIT_W-1] && (credit_reg[i] != '0);
      sat_reg <= |sat_flag;
    end
  end

endmodule

// File: tb/tb_dwrr_deficit_table.sv
// Directed bench for dwrr_deficit_table (5 flows, 8-bit credit, quantum 16).
// Define DWRR_QUANTUM_WR_EN for both bench and RTL to exercise runtime quantum writes.
module tb_dwrr_deficit_table;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              init_done;
  logic              replenish_valid = 1'b0;
  logic [2:0]        replenish_flow;
  logic              consume_valid = 1'b0;
  logic [2:0]        consume_flow = '0;
  logic [5:0]        consume_len = '0;
  logic [2:0]        query_flow = '0;
  logic signed [7:0] query_credit;
  logic [4:0]        eligible_mask;
  logic              quantum_wr_en = 1'b0;
  logic [2:0]        quantum_wr_flow = '0;
  logic [5:0]        quantum_wr_data = '0;
  logic              sat_event;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dwrr_deficit_table #(
    .NUM_FLOWS(5), .CREDIT_W(8), .LEN_W(6), .QUANTUM_W(6), .DEFAULT_QUANTUM(16)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .replenish_valid(replenish_valid), .replenish_flow(replenish_flow),
    .consume_valid(consume_valid), .consume_flow(consume_flow), .consume_len(consume_len),
    .query_flow(query_flow), .query_credit(query_credit), .eligible_mask(eligible_mask),
    .quantum_wr_en(quantum_wr_en), .quantum_wr_flow(quantum_wr_flow),
    .quantum_wr_data(quantum_wr_data), .sat_event(sat_event)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic query(input int f, output logic signed [7:0] v);
    query_flow = 3'(f);
    tick();
    v = query_credit;
    $display("query flow=%0d credit=%0d", f, v);
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic reset_and_init();
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_init(n);
    tick();
  endtask

  task automatic consume(input int f, input int len);
    consume_valid = 1'b1; consume_flow = 3'(f); consume_len = 6'(len);
    tick();
    consume_valid = 1'b0;
    $display("consume flow=%0d len=%0d", f, len);
  endtask

  task automatic replenish(input int count);
    replenish_valid = 1'b1;
    repeat (count) tick();
    replenish_valid = 1'b0;
    $display("replenish x%0d ptr=%0d", count, replenish_flow);
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    tick(); tick();
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got=%b exp=0", init_done); end
    checks++; if (replenish_flow !== 3'd0) begin errors++; $display("FAIL rst_ptr got=%0d exp=0", replenish_flow); end
    checks++; if (query_credit !== 8'sd0) begin errors++; $display("FAIL rst_query got=%0d exp=0", query_credit); end
    checks++; if (eligible_mask !== 5'b0) begin errors++; $display("FAIL rst_mask got=%b exp=00000", eligible_mask); end
    checks++; if (sat_event !== 1'b0) begin errors++; $display("FAIL rst_sat got=%b exp=0", sat_event); end
    rst = 1'b0;
    wait_init(n);
    checks++; if (n != 5) begin errors++; $display("FAIL init_latency got=%0d exp=5", n); end
    $display("reset released, init_done after %0d cycles", n);
  endtask

  task automatic test_init();
    logic signed [7:0] v;
    tick();
    checks++; if (eligible_mask !== 5'b11111) begin errors++; $display("FAIL init_mask got=%b exp=11111", eligible_mask); end
    for (int f = 0; f < 5; f++) begin
      query(f, v);
      checks++; if (v !== 8'sd16) begin errors++; $display("FAIL init_credit%0d got=%0d exp=16", f, v); end
    end
  endtask

  task automatic test_debit_wrap();
    logic signed [7:0] v;
    consume(2, 20);
    query(2, v);
    checks++; if (v !== 8'hFC) begin errors++; $display("FAIL debit_credit2 got=%0d exp=-4", v); end
    checks++; if (eligible_mask !== 5'b11011) begin errors++; $display("FAIL debit_mask got=%b exp=11011", eligible_mask); end
    replenish(5);
    checks++; if (replenish_flow !== 3'd0) begin errors++; $display("FAIL wrap_ptr got=%0d exp=0", replenish_flow); end
    query(2, v);
    checks++; if (v !== 8'sd12) begin errors++; $display("FAIL wrap_credit2 got=%0d exp=12", v); end
    query(0, v);
    checks++; if (v !== 8'sd32) begin errors++; $display("FAIL wrap_credit0 got=%0d exp=32", v); end
  endtask

  task automatic test_simultaneous();
    logic signed [7:0] v;
    reset_and_init();
    replenish_valid = 1'b1; consume_valid = 1'b1; consume_flow = 3'd0; consume_len = 6'd10;
    tick();
    replenish_valid = 1'b0; consume_valid = 1'b0;
    $display("replenish+consume flow=0 len=10");
    checks++; if (replenish_flow !== 3'd1) begin errors++; $display("FAIL simul_ptr got=%0d exp=1", replenish_flow); end
    query(0, v);
    checks++; if (v !== 8'sd22) begin errors++; $display("FAIL simul_credit0 got=%0d exp=22", v); end
    query(1, v);
    checks++; if (v !== 8'sd16) begin errors++; $display("FAIL simul_credit1 got=%0d exp=16", v); end
  endtask

  task automatic test_saturation();
    logic signed [7:0] v;
    reset_and_init();
    consume(0, 8);
    replenish(35);
    query(0, v);
    checks++; if (v !== 8'sd120) begin errors++; $display("FAIL sat_setup got=%0d exp=120", v); end
    replenish(1);
    checks++; if (sat_event !== 1'b1) begin errors++; $display("FAIL sat_hi_pulse got=%b exp=1", sat_event); end
    tick();
    checks++; if (sat_event !== 1'b0) begin errors++; $display("FAIL sat_hi_single got=%b exp=0", sat_event); end
    query(0, v);
    checks++; if (v !== 8'sd127) begin errors++; $display("FAIL sat_hi_credit got=%0d exp=127", v); end

    reset_and_init();
    consume(3, 63);
    consume(3, 63);
    checks++; if (sat_event !== 1'b0) begin errors++; $display("FAIL sat_none got=%b exp=0", sat_event); end
    consume(3, 10);
    query(3, v);
    checks++; if (v !== 8'h88) begin errors++; $display("FAIL sat_lo_setup got=%0d exp=-120", v); end
    consume(3, 63);
    checks++; if (sat_event !== 1'b1) begin errors++; $display("FAIL sat_lo_pulse got=%b exp=1", sat_event); end
    query(3, v);
    checks++; if (v !== 8'h80) begin errors++; $display("FAIL sat_lo_credit got=%0d exp=-128", v); end
    checks++; if (eligible_mask !== 5'b10111) begin errors++; $display("FAIL sat_lo_mask got=%b exp=10111", eligible_mask); end
  endtask

  task automatic test_out_of_range();
    logic signed [7:0] v;
    reset_and_init();
    consume(0, 5);
    consume(7, 30);
    consume(5, 30);
    query(0, v);
    checks++; if (v !== 8'sd11) begin errors++; $display("FAIL oob_credit0 got=%0d exp=11", v); end
    query(5, v);
    checks++; if (v !== 8'sd0) begin errors++; $display("FAIL oob_query5 got=%0d exp=0", v); end
    for (int f = 1; f < 5; f++) begin
      query(f, v);
      checks++; if (v !== 8'sd16) begin errors++; $display("FAIL oob_credit%0d got=%0d exp=16", f, v); end
    end
  endtask

  task automatic test_reset_mid_run();
    logic signed [7:0] v;
    int n;
    reset_and_init();
    consume(1, 5);
    replenish(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL mid_init_done got=%b exp=0", init_done); end
    checks++; if (replenish_flow !== 3'd0) begin errors++; $display("FAIL mid_ptr got=%0d exp=0", replenish_flow); end
    checks++; if (eligible_mask !== 5'b0) begin errors++; $display("FAIL mid_mask got=%b exp=00000", eligible_mask); end
    // Strobes during the walk must be ignored.
    replenish_valid = 1'b1; consume_valid = 1'b1; consume_flow = 3'd0; consume_len = 6'd20;
    wait_init(n);
    replenish_valid = 1'b0; consume_valid = 1'b0;
    $display("mid-run reset, init_done after %0d cycles", n);
    checks++; if (n != 5) begin errors++; $display("FAIL mid_latency got=%0d exp=5", n); end
    checks++; if (replenish_flow !== 3'd0) begin errors++; $display("FAIL mid_ptr_after got=%0d exp=0", replenish_flow); end
    for (int f = 0; f < 5; f++) begin
      query(f, v);
      checks++; if (v !== 8'sd16) begin errors++; $display("FAIL mid_credit%0d got=%0d exp=16", f, v); end
    end
  endtask

  task automatic test_quantum();
    logic signed [7:0] v;
    reset_and_init();
    quantum_wr_en = 1'b1; quantum_wr_flow = 3'd1; quantum_wr_data = 6'd40;
    tick();
    quantum_wr_en = 1'b0;
    replenish(2);
    query(1, v);
`ifdef DWRR_QUANTUM_WR_EN
    checks++; if (v !== 8'sd56) begin errors++; $display("FAIL quantum_credit1 got=%0d exp=56", v); end
`else
    checks++; if (v !== 8'sd32) begin errors++; $display("FAIL quantum_credit1 got=%0d exp=32", v); end
`endif
    // Write to flow 2 in the same cycle it is replenished: old quantum applies.
    quantum_wr_en = 1'b1; quantum_wr_flow = 3'd2; quantum_wr_data = 6'd8;
    replenish_valid = 1'b1;
    tick();
    quantum_wr_en = 1'b0; replenish_valid = 1'b0;
    query(2, v);
    checks++; if (v !== 8'sd32) begin errors++; $display("FAIL quantum_same_cycle got=%0d exp=32", v); end
    replenish(5);
    query(2, v);
`ifdef DWRR_QUANTUM_WR_EN
    checks++; if (v !== 8'sd40) begin errors++; $display("FAIL quantum_new_q2 got=%0d exp=40", v); end
`else
    checks++; if (v !== 8'sd48) begin errors++; $display("FAIL quantum_new_q2 got=%0d exp=48", v); end
`endif
  endtask

  initial begin
    test_reset();
    test_init();
    test_debit_wrap();
    test_simultaneous();
    test_saturation();
    test_out_of_range();
    test_reset_mid_run();
    test_quantum();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dwrr_deficit_table.md
DWRR_DEFICIT_TABLE -- requirements
Module: dwrr_deficit_table

Interface
REQ-001 SHALL have parameter NUM_FLOWS, default 8, number of flows (any value >= 2, not restricted to powers of two).
REQ-002 SHALL have parameter FLOW_W, default $clog2(NUM_FLOWS), flow index width.
REQ-003 SHALL have parameter CREDIT_W, default 12, signed two's-complement deficit counter width.
REQ-004 SHALL have parameter LEN_W, default 10, unsigned packet length width, LEN_W < CREDIT_W.
REQ-005 SHALL have parameter QUANTUM_W, default 10, unsigned quantum width, QUANTUM_W < CREDIT_W.
REQ-006 SHALL have parameter DEFAULT_QUANTUM, default 256, initial quantum and initial credit of every flow.
REQ-007 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-008 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-009 SHALL have port init_done  out  1  high once the table walk completes.
REQ-010 SHALL have port replenish_valid  in  1  end-of-packet strobe; adds one quantum to the flow at the round-robin pointer.
REQ-011 SHALL have port replenish_flow  out  FLOW_W  current round-robin pointer.
REQ-012 SHALL have ports consume_valid in 1, consume_flow in FLOW_W, consume_len in LEN_W  debit consume_len from consume_flow.
REQ-013 SHALL have ports query_flow in FLOW_W, query_credit out CREDIT_W  registered credit readback.
REQ-014 SHALL have port eligible_mask  out  NUM_FLOWS  bit i high when credit[i] > 0.
REQ-015 SHALL have ports quantum_wr_en in 1, quantum_wr_flow in FLOW_W, quantum_wr_data in QUANTUM_W  runtime quantum update (see REQ-030).
REQ-016 SHALL have port sat_event  out  1  one-cycle pulse when any update clamps.

Function
REQ-017 SHALL implement states INIT and RUN; INIT walks index 0..NUM_FLOWS-1 one entry per cycle, writing credit = DEFAULT_QUANTUM and quantum = DEFAULT_QUANTUM, then enters RUN with init_done = 1.
REQ-018 SHALL ignore replenish_valid, consume_valid and quantum_wr_en while in INIT.
REQ-019 SHALL, on replenish_valid in RUN, add quantum[replenish_flow] to credit[replenish_flow] and advance the pointer, wrapping from NUM_FLOWS-1 to 0.
REQ-020 SHALL, on consume_valid in RUN, subtract zero-extended consume_len from credit[consume_flow].
REQ-021 SHALL, when both strobes target the same flow in one cycle, apply credit + quantum - len as a single update with a single saturation.
REQ-022 SHALL saturate credit to the range [-2^(CREDIT_W-1), 2^(CREDIT_W-1)-1] and pulse sat_event the cycle after a clamp.
REQ-023 SHALL return query_credit one cycle after query_flow, showing the table contents before that cycle's updates.
REQ-024 SHALL register eligible_mask, so it reflects updates one cycle after they are applied.
REQ-025 SHALL treat a consume_flow or query_flow >= NUM_FLOWS as a no-op; for such a query_flow, query_credit = 0.

Reset
REQ-026 SHALL, with rst high at any cycle including mid-walk or mid-run, enter INIT at index 0 on the next edge.
REQ-027 SHALL drive these reset values: init_done = 0, replenish_flow = 0, query_credit = 0, eligible_mask = 0, sat_event = 0.
REQ-028 SHALL keep init_done low for exactly NUM_FLOWS cycles after rst deasserts.

Configuration
REQ-029 SHALL use macro DWRR_QUANTUM_WR_EN to control runtime quantum programming.
REQ-030 SHALL, with DWRR_QUANTUM_WR_EN defined and in RUN, write quantum_wr_data to quantum[quantum_wr_flow], effective from the next cycle; a same-cycle replenish of that flow uses the old quantum.
REQ-031 SHALL, without DWRR_QUANTUM_WR_EN, ignore the quantum_wr_* ports, hold every quantum at DEFAULT_QUANTUM, and instantiate no quantum storage.

Verification (NUM_FLOWS=5, CREDIT_W=8, LEN_W=6, QUANTUM_W=6, DEFAULT_QUANTUM=16)
REQ-032 SHALL cover init: deassert rst -> init_done rises after 5 cycles; query of flows 0..4 returns 16 each; eligible_mask = 5'b11111.
REQ-033 SHALL cover debit and wrap: consume flow 2, len 20 -> credit 2 = -4 and eligible_mask[2] = 0; then 5 replenishes -> credit 2 = 12 and replenish_flow back at 0.
REQ-034 SHALL cover simultaneous events: replenish at pointer 0 plus consume flow 0, len 10, same cycle -> credit 0 = 22.
REQ-035 SHALL cover saturation: flow 0 at 120, replenish -> credit 0 = 127 and a single-cycle sat_event; flow at -120, consume 63 -> -128 and sat_event.
REQ-036 SHALL cover reset mid-run: rst for 1 cycle after changed credits -> init_done = 0 next cycle, walk restarts, all credits return to 16, pointer = 0.
REQ-037 SHALL cover the macro: with DWRR_QUANTUM_WR_EN, write flow 1 quantum = 40, then replenish at pointer 1 -> credit 1 = 56; without the macro -> credit 1 = 32.
